// File: rtl/dnp3_pkg.sv
// rtl/dnp3_pkg.sv - shared DNP3 link-layer constants, state encoding and CRC step
//
// Contents:
//   START_BYTE1/START_BYTE2  fixed link-header sync bytes
//   DNP3_MIN_LEN             smallest legal LEN field
//   CTRL_*                   control-byte bit positions
//   tx_state_e               header transmitter state encoding
//   crc16_dnp_step()         one-byte update of the DNP3 CRC-16 (reflected 0x3D65)
//   CRC_HDR_SEED             CRC register contents after the two start bytes
package dnp3_pkg;

  localparam logic [7:0] START_BYTE1  = 8'h05;
  localparam logic [7:0] START_BYTE2  = 8'h64;
  localparam logic [7:0] DNP3_MIN_LEN = 8'd5;

  localparam int CTRL_DIR       = 7;
  localparam int CTRL_PRM       = 6;
  localparam int CTRL_FCB       = 5;
  localparam int CTRL_FCV       = 4;
  localparam int CTRL_FUNC_MSB  = 3;
  localparam int CTRL_FUNC_LSB  = 0;

  // Bit-reversed form of polynomial 0x3D65; the CRC shifts LSB first.
  localparam logic [15:0] CRC_POLY_REV = 16'hA6BC;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START1,
    S_START2,
    S_LEN,
    S_CTRL,
    S_DEST_L,
    S_DEST_H,
    S_SRC_L,
    S_SRC_H,
    S_CRC_L,
    S_CRC_H
  } tx_state_e;

  function automatic logic [15:0] crc16_dnp_step(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REV) : (c >> 1);
    end
    return c;
  endfunction

  // The header CRC covers the two constant start bytes; their contribution
  // is folded into the seed so the transmitter only feeds LEN..SRC_H.
  localparam logic [15:0] CRC_HDR_SEED =
    crc16_dnp_step(crc16_dnp_step(16'h0000, START_BYTE1), START_BYTE2);

endpackage

// File: rtl/crc16_dnp.sv
// rtl/crc16_dnp.sv - byte-wide DNP3 CRC-16 accumulator, one byte per cycle
//
// Parameters:
//   INIT        register value loaded on rst / crc_clear
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset (loads INIT)
//   data_in     byte to accumulate
//   data_valid  accumulate data_in this cycle
//   crc_clear   reload INIT (has priority over data_valid)
//   crc_out     complemented CRC, low byte is transmitted first
module crc16_dnp
  import dnp3_pkg::*;
#(
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        crc_clear,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || crc_clear) begin
      crc_q <= INIT;
    end else if (data_valid) begin
      crc_q <= crc16_dnp_step(crc_q, data_in);
    end
  end

  assign crc_out = ~crc_q;

endmodule

// File: rtl/dnp3_link_tx.sv
// rtl/dnp3_link_tx.sv - DNP3 link-layer 10-byte header serialiser with on-the-fly CRC
//
// Serialises 05 64 LEN CTRL DEST_L DEST_H SRC_L SRC_H CRC_L CRC_H onto a
// valid/ready byte stream. Optional macro DNP3_LINK_TX_FCB_EN replaces the
// FCB bit of FCV frames with an internal toggling frame-count bit.
//
// Parameters:
//   MY_ADDRESS  source address sent in SRC_L/SRC_H
//   MIN_LEN     smallest accepted LEN value
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_valid   header request present
//   req_ready   request can be accepted (IDLE, not in reset)
//   req_ctrl    control byte
//   req_dest    destination address
//   req_len     LEN field, sent verbatim
//   tx_data     outbound byte
//   tx_valid    tx_data valid
//   tx_ready    downstream accepts byte
//   busy        frame in progress
//   frame_done  one-cycle pulse after CRC_H is accepted
//   req_error   one-cycle pulse after a rejected request
module dnp3_link_tx
  import dnp3_pkg::*;
#(
  parameter logic [15:0] MY_ADDRESS = 16'h0001,
  parameter logic [7:0]  MIN_LEN    = DNP3_MIN_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_ctrl,
  input  logic [15:0] req_dest,
  input  logic [7:0]  req_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        req_error
);

  tx_state_e   state_q;
  tx_state_e   state_d;
  logic [7:0]  ctrl_q;
  logic [15:0] dest_q;
  logic [7:0]  len_q;
  logic        frame_done_q;
  logic        req_error_q;

  logic [7:0]  ctrl_tx;
  logic [15:0] crc_out;
  logic        accept;
  logic        accept_ok;
  logic        xfer;
  logic        crc_feed;

  assign req_ready = !rst && (state_q == S_IDLE);
  assign tx_valid  = (state_q != S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign accept_ok = accept && (req_len >= MIN_LEN);
  assign xfer      = tx_valid && tx_ready;
  assign crc_feed  = xfer && (state_q inside {S_LEN, S_CTRL, S_DEST_L,
                                              S_DEST_H, S_SRC_L, S_SRC_H});

  assign frame_done = frame_done_q;
  assign req_error  = req_error_q;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_START1: state_d = S_START2;
      S_START2: state_d = S_LEN;
      S_LEN:    state_d = S_CTRL;
      S_CTRL:   state_d = S_DEST_L;
      S_DEST_L: state_d = S_DEST_H;
      S_DEST_H: state_d = S_SRC_L;
      S_SRC_L:  state_d = S_SRC_H;
      S_SRC_H:  state_d = S_CRC_L;
      S_CRC_L:  state_d = S_CRC_H;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctrl_q       <= 8'h00;
      dest_q       <= 16'h0000;
      len_q        <= 8'h00;
      frame_done_q <= 1'b0;
      req_error_q  <= 1'b0;
    end else begin
      frame_done_q <= xfer && (state_q == S_CRC_H);
      req_error_q  <= accept && !accept_ok;
      // accept only happens in IDLE and xfer only outside IDLE.
      if (accept_ok) begin
        ctrl_q  <= req_ctrl;
        dest_q  <= req_dest;
        len_q   <= req_len;
        state_q <= S_START1;
      end else if (xfer) begin
        state_q <= state_d;
      end
    end
  end

`ifdef DNP3_LINK_TX_FCB_EN
  logic fcb_q;

  // ctrl_q still holds the finished frame during the frame_done cycle,
  // even if a new request is accepted in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcb_q <= 1'b1;
    end else if (frame_done_q && ctrl_q[CTRL_FCV]) begin
      fcb_q <= ~fcb_q;
    end
  end

  always_comb begin
    ctrl_tx = ctrl_q;
    if (ctrl_q[CTRL_FCV]) begin
      ctrl_tx[CTRL_FCB] = fcb_q;
    end
  end
`else
  assign ctrl_tx = ctrl_q;
`endif

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_START1: tx_data = START_BYTE1;
      S_START2: tx_data = START_BYTE2;
      S_LEN:    tx_data = len_q;
      S_CTRL:   tx_data = ctrl_tx;
      S_DEST_L: tx_data = dest_q[7:0];
      S_DEST_H: tx_data = dest_q[15:8];
      S_SRC_L:  tx_data = MY_ADDRESS[7:0];
      S_SRC_H:  tx_data = MY_ADDRESS[15:8];
      S_CRC_L:  tx_data = crc_out[7:0];
      S_CRC_H:  tx_data = crc_out[15:8];
      default:  tx_data = 8'h00;
    endcase
  end

  crc16_dnp #(
    .INIT (CRC_HDR_SEED)
  ) u_crc (
    .clk        (clk),
    .rst        (rst),
    .data_in    (tx_data),
    .data_valid (crc_feed),
    .crc_clear  (accept_ok),
    .crc_out    (crc_out)
  );

endmodule

// File: tb/tb_dnp3_link_tx.sv
// tb/tb_dnp3_link_tx.sv - self-checking bench for dnp3_link_tx against a bit-serial reference
module tb_dnp3_link_tx;

  typedef logic [9:0][7:0] frame_t;

`ifdef DNP3_LINK_TX_FCB_EN
  localparam bit FCB_EN = 1'b1;
`else
  localparam bit FCB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_ctrl;
  logic [15:0] req_dest;
  logic [7:0]  req_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic        req_error;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  bit fcb_m     = 1'b1;

  dnp3_link_tx #(
    .MY_ADDRESS (16'h0400)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .req_error  (req_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: bit-serial, LSB first, over all eight header bytes.
  function automatic logic [15:0] ref_crc(input frame_t f);
    logic [15:0] crc;
    logic        fb;
    crc = 16'h0000;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) begin
        fb  = crc[0] ^ f[b][k];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA6BC;
      end
    end
    return ~crc;
  endfunction

  function automatic frame_t exp_frame(input logic [7:0] ctrl, input logic [15:0] dest,
                                       input logic [7:0] len);
    frame_t      f;
    logic [7:0]  c;
    logic [15:0] crc;
    c = ctrl;
    if (FCB_EN && c[4]) c[5] = fcb_m;
    f[0] = 8'h05;       f[1] = 8'h64;
    f[2] = len;         f[3] = c;
    f[4] = dest[7:0];   f[5] = dest[15:8];
    f[6] = 8'h00;       f[7] = 8'h04;
    crc  = ref_crc(f);
    f[8] = crc[7:0];    f[9] = crc[15:8];
    return f;
  endfunction

  task automatic finish_frame(input logic [7:0] ctrl);
    if (FCB_EN && ctrl[4]) fcb_m = ~fcb_m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fcb_m = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic issue_req(input logic [7:0] ctrl, input logic [15:0] dest, input logic [7:0] len);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_ctrl  = ctrl;
    req_dest  = dest;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    req_ctrl  = 8'($urandom);
    req_dest  = 16'($urandom);
    req_len   = 8'($urandom);
  endtask

  // Entered at the negedge where START1 must be visible; leaves at the
  // negedge of the cycle following the CRC_H transfer.
  task automatic recv_frame(input frame_t e, input int stall_pct, input string tag,
                            output int cycles);
    int idx;
    idx    = 0;
    cycles = 0;
    check({tag, "_first_valid"}, tx_valid, 1'b1);
    while (idx < 10 && cycles < 400) begin
      check({tag, "_valid"}, tx_valid, 1'b1);
      check({tag, $sformatf("_byte%0d", idx)}, tx_data, e[idx]);
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_req_ready_low"}, req_ready, 1'b0);
      check({tag, "_no_early_done"}, frame_done, 1'b0);
      tx_ready = ($urandom_range(99) >= stall_pct);
      if (tx_valid && tx_ready) idx++;
      @(negedge clk);
      cycles++;
    end
    check({tag, "_byte_count"}, idx, 10);
    check({tag, "_frame_done"}, frame_done, 1'b1);
    check({tag, "_idle_valid"}, tx_valid, 1'b0);
    check({tag, "_idle_ready"}, req_ready, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    frame_t      v1;
    frame_t      ea;
    frame_t      eb;
    logic [7:0]  ca;
    logic [7:0]  cb;
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  l;
    int          cyc;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_ctrl  = 8'h00;
    req_dest  = 16'h0000;
    req_len   = 8'h00;
    tx_ready  = 1'b0;

    v1[0] = 8'h05; v1[1] = 8'h64; v1[2] = 8'h05; v1[3] = 8'hC0; v1[4] = 8'h01;
    v1[5] = 8'h00; v1[6] = 8'h00; v1[7] = 8'h04; v1[8] = 8'hE9; v1[9] = 8'h21;

    do_reset();
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_req_error", req_error, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);

    // Known vector, no back-pressure: ten consecutive cycles.
    issue_req(8'hC0, 16'h0001, 8'd5);
    recv_frame(v1, 0, "vec1", cyc);
    check("vec1_cycles", cyc, 10);
    @(negedge clk);
    check("vec1_done_pulse", frame_done, 1'b0);

    // Same vector with heavy back-pressure.
    issue_req(8'hC0, 16'h0001, 8'd5);
    recv_frame(v1, 45, "stall", cyc);
    @(negedge clk);

    // Rejected request, then a normal one.
    tx_ready  = 1'b1;
    req_valid = 1'b1;
    req_ctrl  = 8'hC4;
    req_dest  = 16'h1234;
    req_len   = 8'd4;
    @(negedge clk);
    check("rej_error", req_error, 1'b1);
    check("rej_tx_valid", tx_valid, 1'b0);
    check("rej_req_ready", req_ready, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    check("rej_error_single", req_error, 1'b0);
    check("rej_tx_valid2", tx_valid, 1'b0);
    c = 8'($urandom);
    d = 16'($urandom);
    ea = exp_frame(c, d, 8'd5);
    issue_req(c, d, 8'd5);
    recv_frame(ea, 30, "after_rej", cyc);
    finish_frame(c);
    @(negedge clk);

    // Reset after the DEST_L transfer.
    issue_req(8'hC0, 16'h0001, 8'd5);
    repeat (5) begin
      tx_ready = 1'b1;
      @(negedge clk);
    end
    check("abort_pre_data", tx_data, 8'h00);
    rst = 1'b1;
    fcb_m = 1'b1;
    @(negedge clk);
    check("abort_tx_valid", tx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_no_done", frame_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_done2", frame_done, 1'b0);
    check("abort_req_ready", req_ready, 1'b1);
    issue_req(8'hC0, 16'h0001, 8'd5);
    recv_frame(v1, 30, "post_abort", cyc);
    @(negedge clk);

    // Random requests against the reference model.
    for (int n = 0; n < 5; n++) begin
      c = 8'($urandom);
      d = 16'($urandom);
      l = 8'($urandom_range(255, 5));
      ea = exp_frame(c, d, l);
      issue_req(c, d, l);
      recv_frame(ea, $urandom_range(60, 30), $sformatf("rnd%0d", n), cyc);
      finish_frame(c);
      if ($urandom_range(1)) @(negedge clk);
    end

    // Back-to-back with req_valid held high.
    ca = 8'($urandom);
    cb = 8'($urandom);
    d  = 16'($urandom);
    ea = exp_frame(ca, d, 8'd7);
    req_valid = 1'b1;
    req_ctrl  = ca;
    req_dest  = d;
    req_len   = 8'd7;
    @(negedge clk);
    req_ctrl  = cb;
    req_dest  = ~d;
    req_len   = 8'd9;
    recv_frame(ea, 35, "b2b_a", cyc);
    finish_frame(ca);
    eb = exp_frame(cb, ~d, 8'd9);
    @(negedge clk);
    req_valid = 1'b0;
    recv_frame(eb, 35, "b2b_b", cyc);
    finish_frame(cb);
    @(negedge clk);

    // FCV frames: F3, non-FCV C0 between, F3 again.
    do_reset();
    ea = exp_frame(8'hF3, 16'h0001, 8'd5);
    issue_req(8'hF3, 16'h0001, 8'd5);
    recv_frame(ea, 30, "fcv1", cyc);
    finish_frame(8'hF3);
    @(negedge clk);
    issue_req(8'hC0, 16'h0001, 8'd5);
    recv_frame(v1, 30, "fcv_mid", cyc);
    @(negedge clk);
    ea = exp_frame(8'hF3, 16'h0001, 8'd5);
    issue_req(8'hF3, 16'h0001, 8'd5);
    recv_frame(ea, 30, "fcv2", cyc);
    finish_frame(8'hF3);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
